// File: rtl/morse_timing_classifier.sv
// ---------------------------------------------------------------------------
// morse_timing_classifier
//
// Classifies the debounced Morse key level into single-cycle symbol and gap
// pulses. Mark (pressed) and space (released) durations are measured in time
// units produced by an internal prescaler. A unit is TIMER_FINAL_VALUE+1 clk
// cycles long.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   b      in   debounced key level (1 = pressed), synchronous to clk
//   dot    out  one-cycle pulse: a mark shorter than DASH_UNITS units ended
//   dash   out  one-cycle pulse: a mark of at least DASH_UNITS units ended
//   lg     out  one-cycle pulse: letter gap reached (LG_UNITS of space)
//   wg     out  one-cycle pulse: word gap reached (WG_UNITS of space)
//   mark   out  high while the classifier is in the MARK state
//   units  out  current saturating unit count (debug)
//
// Handshake: there is none. Every pulse output is registered and high for
// exactly one cycle after the clk edge that triggered it; the consumer must
// sample it on that cycle. dot, dash, lg and wg are never high together.
// ---------------------------------------------------------------------------
module morse_timing_classifier #(
    parameter int TIMER_FINAL_VALUE = 9_999_999,
    parameter int DASH_UNITS        = 2,
    parameter int LG_UNITS          = 3,
    parameter int WG_UNITS          = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b,
    output logic       dot,
    output logic       dash,
    output logic       lg,
    output logic       wg,
    output logic       mark,
    output logic [3:0] units
);

    // Prescaler width; at least one bit even for a one-cycle unit.
    localparam int PW = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // released, no pending symbol
        MARK      = 2'd1,  // pressed
        SPACE_SYM = 2'd2,  // released, symbols pending, lg not yet issued
        SPACE_LTR = 2'd3   // released, lg issued, wg not yet issued
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            b_q;
    logic [PW-1:0]   presc_q;
    logic [3:0]      units_q;

    logic            det;
    logic            rise;
    logic            fall;
    logic            tick;
    logic [4:0]      units_inc;

    logic            dot_d;
    logic            dash_d;
    logic            lg_d;
    logic            wg_d;
    logic            mark_d;

    // Any change of the key level restarts both the prescaler and the unit
    // count, so each mark or space is timed from its own detect edge.
    assign det  = b ^ b_q;
    assign rise = det & b;
    assign fall = det & ~b;
    assign tick = (presc_q == PW'(TIMER_FINAL_VALUE));

    // One wider than units_q so the saturated value 15 cannot wrap to 0 when
    // compared against the gap thresholds.
    assign units_inc = {1'b0, units_q} + 5'd1;

    // -----------------------------------------------------------------------
    // Edge detect, prescaler and unit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q     <= 1'b0;
            presc_q <= '0;
            units_q <= 4'd0;
        end else begin
            b_q <= b;

            if (det || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end

            // A tick landing on a detect edge is dropped: the clear wins.
            if (det) begin
                units_q <= 4'd0;
            end else if (tick && (units_q != 4'd15)) begin
                units_q <= units_q + 4'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Classifier FSM: state register and registered pulse outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dot     <= 1'b0;
            dash    <= 1'b0;
            lg      <= 1'b0;
            wg      <= 1'b0;
            mark    <= 1'b0;
        end else begin
            state_q <= state_d;
            dot     <= dot_d;
            dash    <= dash_d;
            lg      <= lg_d;
            wg      <= wg_d;
            mark    <= mark_d;
        end
    end

    // Next state and pulse decode. The dot/dash decision uses units_q as it
    // stands before the falling detect clears it. The gap thresholds test the
    // count the tick is about to produce, so the pulse lines up with the edge
    // on which the LG_UNITS-th / WG_UNITS-th unit completes.
    always_comb begin
        state_d = state_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        lg_d    = 1'b0;
        wg_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MARK;
                end
            end

            MARK: begin
                if (fall) begin
                    state_d = SPACE_SYM;
                    if (int'(units_q) < DASH_UNITS) begin
                        dot_d = 1'b1;
                    end else begin
                        dash_d = 1'b1;
                    end
                end
            end

            SPACE_SYM: begin
                // A new press cancels the pending gap before any tick counts.
                if (rise) begin
                    state_d = MARK;
                end else if (tick && (int'(units_inc) == LG_UNITS)) begin
                    state_d = SPACE_LTR;
                    lg_d    = 1'b1;
                end
            end

            SPACE_LTR: begin
                if (rise) begin
                    state_d = MARK;
                end else if (tick && (int'(units_inc) == WG_UNITS)) begin
                    state_d = IDLE;
                    wg_d    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        mark_d = (state_d == MARK);
    end

    assign units = units_q;

endmodule

// File: tb/tb_morse_timing_classifier.sv
// ---------------------------------------------------------------------------
// tb_morse_timing_classifier
//
// Drives key press/release intervals of known length (directed boundary
// cases followed by random ones). For each interval the expected pulses are
// computed from the timing rules (unit = 10 clk, dot/dash threshold, gap
// thresholds) and pushed as {kind, edge} into exp_q. A monitor on the
// falling clock edge pops and compares whenever any pulse is high, and also
// checks mark and units against the interval the driver is in.
// ---------------------------------------------------------------------------
module tb_morse_timing_classifier;

  localparam int TFV      = 9;
  localparam int UNIT     = TFV + 1;
  localparam int DASH_U   = 2;
  localparam int LG_U     = 3;
  localparam int WG_U     = 7;
  localparam int NONE     = 32'h7fff_ffff;
  localparam int W        = 34;

  localparam logic [1:0] K_DOT  = 2'd0;
  localparam logic [1:0] K_DASH = 2'd1;
  localparam logic [1:0] K_LG   = 2'd2;
  localparam logic [1:0] K_WG   = 2'd3;

  logic       clk;
  logic       reset;
  logic       b;
  logic       dot;
  logic       dash;
  logic       lg;
  logic       wg;
  logic       mark;
  logic [3:0] units;

  logic [W-1:0] exp_q[$];

  int cyc;
  int n_cmp;
  int n_bad;
  bit in_reset;

  // Interval bookkeeping for mark/units expectations.
  int   cur_base;
  logic cur_mark;
  int   chg_edge;
  logic new_mark;

  morse_timing_classifier #(
    .TIMER_FINAL_VALUE (TFV),
    .DASH_UNITS        (DASH_U),
    .LG_UNITS          (LG_U),
    .WG_UNITS          (WG_U)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .b     (b),
    .dot   (dot),
    .dash  (dash),
    .lg    (lg),
    .wg    (wg),
    .mark  (mark),
    .units (units)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Changes b just after a rising edge; the DUT sees the change on the next
  // edge, which is returned as the detect edge.
  task automatic set_b(input logic v, output int det);
    @(posedge clk);
    #1;
    if (chg_edge != NONE) begin
      cur_base = chg_edge;
      cur_mark = new_mark;
    end
    b        = v;
    det      = cyc + 1;
    chg_edge = det;
    new_mark = v;
  endtask

  // Press for p edges, then release for s edges (counted between detect
  // edges). Expected pulses come straight from the unit arithmetic.
  task automatic drive_symbol(input int p, input int s);
    int e_press;
    int e_rel;
    int done_units;
    set_b(1'b1, e_press);
    repeat (p - 1) @(posedge clk);
    set_b(1'b0, e_rel);
    // Units completed strictly before the release edge; a tick on the
    // release edge itself does not count.
    done_units = (p - 1) / UNIT;
    if (done_units < DASH_U) exp_q.push_back({K_DOT, 32'(e_rel)});
    else                     exp_q.push_back({K_DASH, 32'(e_rel)});
    // A gap pulse needs its threshold edge strictly before the next press.
    if (s > LG_U * UNIT) exp_q.push_back({K_LG, 32'(e_rel + LG_U * UNIT)});
    if (s > WG_U * UNIT) exp_q.push_back({K_WG, 32'(e_rel + WG_U * UNIT)});
    repeat (s - 1) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dot"},   dot,   0);
    check({tag, "_dash"},  dash,  0);
    check({tag, "_lg"},    lg,    0);
    check({tag, "_wg"},    wg,    0);
    check({tag, "_mark"},  mark,  0);
    check({tag, "_units"}, units, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    int   npulse;
    logic [1:0] kind;
    logic [W-1:0] item;
    int   base;
    logic m_exp;
    int   u_exp;
    if (!in_reset) begin
      npulse = int'(dot) + int'(dash) + int'(lg) + int'(wg);
      if (npulse > 1) begin
        check("pulse_exclusive", npulse, 1);
      end else if (npulse == 1) begin
        kind = dot ? K_DOT : dash ? K_DASH : lg ? K_LG : K_WG;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_kind", kind, 4);
        end else begin
          item = exp_q.pop_front();
          check("pulse_kind", kind, item[33:32]);
          check("pulse_edge", cyc, item[31:0]);
        end
      end

      if (cyc >= chg_edge) begin
        base  = chg_edge;
        m_exp = new_mark;
      end else begin
        base  = cur_base;
        m_exp = cur_mark;
      end
      u_exp = (cyc - base) / UNIT;
      if (u_exp > 15) u_exp = 15;
      check("mark", mark, m_exp);
      check("units", units, u_exp);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    n_cmp    = 0;
    n_bad    = 0;
    in_reset = 1'b1;
    reset    = 1'b1;
    b        = 1'b0;
    cur_base = 0;
    cur_mark = 1'b0;
    chg_edge = NONE;
    new_mark = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset    = 1'b0;
    cur_base = cyc;
    in_reset = 1'b0;

    // Idle before any symbol: nothing may happen.
    repeat (20) @(posedge clk);

    drive_symbol(15, 80);   // dot, then lg at +30 and wg at +70
    drive_symbol(19, 80);   // dot
    drive_symbol(20, 80);   // dot: tick on the release edge is ignored
    drive_symbol(21, 25);   // dash, short space: no lg
    drive_symbol(15, 50);   // dot, lg but no wg
    drive_symbol(200, 80);  // long mark saturates units, still a dash

    for (int i = 0; i < 30; i++) begin
      drive_symbol($urandom_range(1, 45), $urandom_range(1, 90));
    end
    drive_symbol($urandom_range(1, 45), 80);

    // Long idle after the word gap: no further pulses, units saturated.
    repeat (200) @(posedge clk);

    // Reset in the middle of a mark.
    set_b(1'b1, e);
    repeat (26) @(posedge clk);
    #2;
    in_reset = 1'b1;
    reset    = 1'b1;
    #1;
    check_all_zero("async_reset");
    b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    cur_base = cyc;
    cur_mark = 1'b0;
    chg_edge = NONE;
    new_mark = 1'b0;
    in_reset = 1'b0;
    #1;
    check("post_reset_units", units, 0);
    repeat (40) @(posedge clk);

    // One more symbol after reset to confirm normal operation resumes.
    drive_symbol(25, 80);
    repeat (10) @(posedge clk);

    @(negedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
